// File: rtl/div_seq.sv
// Multi-cycle restoring divider with pipeline stall arbitration for HI/LO writes.
// Define DIV_SIGNED_EN to honour signed_i (DIV); otherwise every division is unsigned.
//
// state  | meaning
// IDLE   | waiting for a start request
// BYZERO | divisor was zero, result forced to 0
// ON     | one restoring iteration per cycle
// END    | result_o/ready_o presented until start_i drops
module div_seq #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  annul_i,
    input  logic                  stallreq_id_i,
    input  logic                  stallreq_ex_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o,
    output logic [5:0]            stall_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   dvd;
    logic [DATA_W-1:0]   divisor;

    logic [DATA_W:0]     rem_sh;
    logic [DATA_W:0]     trial;
    logic                q_bit;
    logic [DATA_W-1:0]   rem_nxt;
    logic [DATA_W-1:0]   dvd_nxt;
    logic [DATA_W-1:0]   q_fix;
    logic [DATA_W-1:0]   r_fix;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;

    // Bit shifted out of the dividend joins the partial remainder, giving a 33-bit trial.
    assign rem_sh  = {rem, dvd[DATA_W-1]};
    assign trial   = rem_sh - {1'b0, divisor};
    assign q_bit   = ~trial[DATA_W];
    assign rem_nxt = q_bit ? trial[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    assign dvd_nxt = {dvd[DATA_W-2:0], q_bit};

`ifdef DIV_SIGNED_EN
    logic sign_q;
    logic sign_r;

    always_comb begin
        a_mag = opdata1_i;
        b_mag = opdata2_i;
        if (signed_i && opdata1_i[DATA_W-1]) a_mag = -opdata1_i;
        if (signed_i && opdata2_i[DATA_W-1]) b_mag = -opdata2_i;
        q_fix = sign_q ? -dvd_nxt : dvd_nxt;
        r_fix = sign_r ? -rem_nxt : rem_nxt;
    end
`else
    logic unused_signed;
    assign unused_signed = signed_i;

    always_comb begin
        a_mag = opdata1_i;
        b_mag = opdata2_i;
        q_fix = dvd_nxt;
        r_fix = rem_nxt;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            divisor  <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
`ifdef DIV_SIGNED_EN
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= BYZERO;
                        end else begin
                            state   <= ON;
                            cnt     <= '0;
                            rem     <= '0;
                            dvd     <= a_mag;
                            divisor <= b_mag;
`ifdef DIV_SIGNED_EN
                            sign_q  <= signed_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                            sign_r  <= signed_i & opdata1_i[DATA_W-1];
`endif
                        end
                    end
                end
                BYZERO: begin
                    result_o <= '0;
                    if (annul_i) begin
                        state   <= IDLE;
                        ready_o <= 1'b0;
                    end else begin
                        state   <= END;
                        ready_o <= 1'b1;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state    <= IDLE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else begin
                        rem <= rem_nxt;
                        dvd <= dvd_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            result_o <= {r_fix, q_fix};
                            ready_o  <= 1'b1;
                            state    <= END;
                        end
                    end
                end
                END: begin
                    if (annul_i || !start_i) begin
                        state    <= IDLE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stallreq_o = start_i & ~annul_i & (state != END);

    always_comb begin
        stall_o = 6'b000000;
        if (stallreq_o || stallreq_ex_i)
            stall_o = 6'b001111;
        else if (stallreq_id_i)
            stall_o = 6'b000111;
    end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: vector table, hand-written corner sequences and random
// divisions compared against an arithmetic reference model.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;
    logic [5:0]  stall_o;

    int checks = 0;
    int errors = 0;

    div_seq #(.DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .signed_i      (signed_i),
        .opdata1_i     (opdata1_i),
        .opdata2_i     (opdata2_i),
        .annul_i       (annul_i),
        .stallreq_id_i (stallreq_id_i),
        .stallreq_ex_i (stallreq_ex_i),
        .result_o      (result_o),
        .ready_o       (ready_o),
        .stallreq_o    (stallreq_o),
        .stall_o       (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] res;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero, HI = remainder.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        logic eff_s;
`ifdef DIV_SIGNED_EN
        eff_s = s;
`else
        eff_s = 1'b0;
`endif
        if (b == 32'd0) return 64'd0;
        if (eff_s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Issue one division; lat = edges after the accept edge until ready_o is seen.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [63:0] res, output int lat, output logic stall_ok);
        @(negedge clk);
        start_i   = 1'b1;
        signed_i  = s;
        opdata1_i = a;
        opdata2_i = b;
        #1;
        stall_ok = (stall_o == 6'b001111) && stallreq_o;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                lat = n;
                break;
            end
            if (stall_o != 6'b001111) stall_ok = 1'b0;
        end
        if (lat > 0 && (stall_o != 6'b000000 || stallreq_o)) stall_ok = 1'b0;
        res = result_o;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
    endtask

    vec_t        vecs[7];
    logic [63:0] res;
    int          lat;
    logic        sok;
    logic        seen;

    initial begin
        vecs[0] = '{32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 32};
        vecs[3] = '{32'd5, 32'd0, 1'b0, 64'h0, 1};
        vecs[4] = '{32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 32};
        vecs[5] = '{32'd7, 32'd100, 1'b0, 64'h00000007_00000000, 32};
`ifdef DIV_SIGNED_EN
        vecs[1] = '{32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 32};
        vecs[2] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 32};
        vecs[6] = '{32'd1000, 32'hFFFFFFFD, 1'b1, 64'h00000001_FFFFFEB3, 32};
`else
        vecs[1] = '{32'hFFFFFFF9, 32'd2, 1'b1, 64'h00000001_7FFFFFFC, 32};
        vecs[2] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h80000000_00000000, 32};
        vecs[6] = '{32'd1000, 32'hFFFFFFFD, 1'b1, 64'h000003E8_00000000, 32};
`endif

        rst = 1'b0;
        start_i = 0; signed_i = 0; opdata1_i = 0; opdata2_i = 0;
        annul_i = 0; stallreq_id_i = 0; stallreq_ex_i = 0;
        #1;
        check("reset_result", result_o, 64'd0);
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_stall", {58'd0, stall_o}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        stallreq_id_i = 1'b1;
        #1 check("stall_id_only", {58'd0, stall_o}, 64'b000111);
        stallreq_ex_i = 1'b1;
        #1 check("stall_ex_and_id", {58'd0, stall_o}, 64'b001111);
        stallreq_id_i = 1'b0;
        #1 check("stall_ex_only", {58'd0, stall_o}, 64'b001111);
        stallreq_ex_i = 1'b0;
        #1 check("stall_none", {58'd0, stall_o}, 64'd0);

        for (int i = 0; i < 7; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].s, res, lat, sok);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d_stall", i), {63'd0, sok}, 64'd1);
            check($sformatf("vec%0d_model", i), model(vecs[i].a, vecs[i].b, vecs[i].s), vecs[i].res);
        end

        // Annul at iteration 10: no ready pulse, stall drops, block recovers.
        @(negedge clk);
        start_i = 1; signed_i = 0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        #1 check("annul_stallreq", {63'd0, stallreq_o}, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        #1 check("annul_stall_after", {58'd0, stall_o}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 if (ready_o) seen = 1'b1;
        end
        check("annul_no_ready", {63'd0, seen}, 64'd0);
        run_div(32'd100, 32'd7, 1'b0, res, lat, sok);
        check("annul_recover_result", res, 64'h00000002_0000000E);
        check("annul_recover_latency", 64'(lat), 64'd32);

        // ID stall request while a division runs, then after it completes.
        @(negedge clk);
        start_i = 1; signed_i = 0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        stallreq_id_i = 1'b1;
        #1 check("id_plus_div_stall", {58'd0, stall_o}, 64'b001111);
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1 if (ready_o) begin seen = 1'b1; break; end
        end
        check("id_div_ready", {63'd0, seen}, 64'd1);
        check("id_after_ready_stall", {58'd0, stall_o}, 64'b000111);
        // Annul while presenting the result clears it.
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        check("annul_end_ready", {63'd0, ready_o}, 64'd0);
        check("annul_end_result", result_o, 64'd0);
        @(negedge clk);
        annul_i = 0; start_i = 0; stallreq_id_i = 0;
        @(negedge clk);

        // Reset at iteration 20 aborts asynchronously.
        @(negedge clk);
        start_i = 1; signed_i = 0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("rst_mid_ready", {63'd0, ready_o}, 64'd0);
        check("rst_mid_result", result_o, 64'd0);
        start_i = 1'b0;
        #1 check("rst_mid_stall", {58'd0, stall_o}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_div(32'd100, 32'd7, 1'b0, res, lat, sok);
        check("rst_recover_result", res, 64'h00000002_0000000E);
        check("rst_recover_latency", 64'(lat), 64'd32);

        // Reset while the result is presented clears it without waiting for an edge.
        @(negedge clk);
        start_i = 1; signed_i = 0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        repeat (34) @(posedge clk);
        #1 check("end_ready_before_rst", {63'd0, ready_o}, 64'd1);
        #2 rst = 1'b0;
        #1 check("rst_end_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a, b;
            logic        s;
            int          sel;
            sel = $urandom_range(0, 9);
            a   = (sel == 9) ? 32'h80000000 : $urandom;
            if (sel == 0)      b = 32'd0;
            else if (sel <= 3) b = $urandom_range(1, 16);
            else if (sel == 4) b = 32'hFFFFFFFF;
            else               b = $urandom;
            s = 1'($urandom_range(0, 1));
            run_div(a, b, s, res, lat, sok);
            check($sformatf("rand%0d_result a=%h b=%h s=%0d", i, a, b, s), res, model(a, b, s));
            check($sformatf("rand%0d_latency", i), 64'(lat), (b == 0) ? 64'd1 : 64'd32);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle division sequencer and pipeline stall arbiter for the OpenMIPS core. It accepts DIV/DIVU requests from the EX stage and runs a 32-iteration restoring division. While the division runs, it holds the pipeline frozen through a 6-bit stall vector. The 64-bit result goes back to EX as {remainder, quotient} for the HI/LO write path (HI = remainder, LO = quotient).

## Interface
Parameters:
- DATA_W, 32, operand width; the iteration count equals DATA_W.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start_i  input  1  EX requests a division; held high by EX until it samples ready_o.
- signed_i  input  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  input  DATA_W  dividend.
- opdata2_i  input  DATA_W  divisor.
- annul_i  input  1  cancels a pending or running division (flush).
- stallreq_id_i  input  1  stall request from ID.
- stallreq_ex_i  input  1  stall request from EX for other causes.
- result_o  output  2*DATA_W  {remainder, quotient}.
- ready_o  output  1  result valid.
- stallreq_o  output  1  internal division stall request.
- stall_o  output  6  stall vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.

## Operation
- States:
  - IDLE: no division in progress.
  - BYZERO: divisor was zero.
  - ON: iterating.
  - END: result presented.
- IDLE:
  - start_i=1 and annul_i=0, divisor==0: go to BYZERO.
  - start_i=1 and annul_i=0, divisor!=0: go to ON. Load the operand magnitudes (negate negative operands when signed), clear cnt and the partial remainder, and latch the operand signs.
  - start_i=1 with annul_i=1: ignored.
- BYZERO: result = 0, next state END.
- ON, one iteration per cycle:
  - Shift {rem, dvd} left 1.
  - Compute the 33-bit trial difference rem − divisor.
  - If the trial is non-negative, rem = difference and the quotient bit = 1; otherwise keep rem and the quotient bit = 0.
  - cnt increments each iteration.
  - On the iteration where cnt reaches DATA_W, apply the sign fix and go to END. The quotient is negated if signed and the operand signs differ. The remainder is negated if signed and the dividend is negative.
  - Widths wrap modulo 2^DATA_W; 0x80000000 / −1 gives quotient 0x80000000, remainder 0.
- END: ready_o=1 and result_o valid; both hold while start_i=1. start_i=0 returns the FSM to IDLE.
- annul_i=1 in ON, BYZERO or END: next state IDLE, ready_o stays 0 and result_o is cleared.
- stallreq_o = start_i & ~annul_i & (state != END). This is combinational and also covers the IDLE accept cycle.
- stall_o, combinational, with priority EX over ID:
  - stallreq_o | stallreq_ex_i gives 6'b001111.
  - Otherwise stallreq_id_i gives 6'b000111.
  - Otherwise 6'b000000.

## Timing
- Reset (rst=0, asynchronous) puts the block in this state:
  - state IDLE
  - cnt = 0
  - result_o = 0
  - ready_o = 0
  - stall_o = 0 (driven by stallreq_* only, since state is IDLE)
- result_o and ready_o are registered.
- Latency, with start accepted at edge t (IDLE):
  - Nonzero divisor: ON is visible from t+1, 32 iterations run on edges t+1 … t+32, and ready_o=1 from t+33.
  - Divide by zero: BYZERO at t+1, END with ready_o=1 at t+2.
- stallreq_o is high from the cycle start_i rises through the last ON cycle. It drops in the cycle ready_o rises, so EX consumes the result exactly once.
- Reset mid-operation aborts immediately, with no ready pulse.
- A new start needs at least one IDLE cycle after END (start_i low for at least 1 cycle).

## Configuration
- DIV_SIGNED_EN defined: signed_i is honoured (operand magnitude conversion and sign fix as above).
- DIV_SIGNED_EN undefined: signed_i is ignored and all divisions are unsigned. The negation logic is removed.

## Test plan
- Unsigned 100/7 (signed_i=0) → ready_o at t+33, result_o = 64'h00000002_0000000E; stall_o = 001111 from t through t+32, 000000 at t+33.
- Signed −7/2 (0xFFFFFFF9 / 0x2) → result_o = 64'hFFFFFFFF_FFFFFFFD. Signed 0x80000000 / 0xFFFFFFFF → result_o = 64'h00000000_80000000. Without DIV_SIGNED_EN, 0xFFFFFFF9 / 2 → 64'h00000001_7FFFFFFC.
- Divisor 0 (5/0) → ready_o at t+2, result_o = 0, stallreq_o low from t+2.
- annul_i pulsed at iteration 10 → state IDLE next cycle, ready_o never asserts, stallreq_o low once start_i drops.
- stallreq_id_i=1 alone → stall_o = 000111. stallreq_id_i=1 plus a running division → 001111. stallreq_ex_i=1 → 001111.
- rst asserted at iteration 20 → outputs zero asynchronously. After release, a new 100/7 completes correctly in 33 cycles.
